// File: rtl/k6502_seq_pkg.sv
// Shared k6502 definitions: cycle and sequence-select encodings.
// The microcode decoder addresses its ROM with the same constants.
package k6502_seq_pkg;

  typedef logic [5:0] cycle_t;
  typedef logic [1:0] seq_sel_t;

  // One-hot cycle; all-zero is the opcode fetch cycle.
  localparam cycle_t C_N = 6'b000000;
  localparam cycle_t C_0 = 6'b000001;
  localparam cycle_t C_1 = 6'b000010;
  localparam cycle_t C_2 = 6'b000100;
  localparam cycle_t C_3 = 6'b001000;
  localparam cycle_t C_4 = 6'b010000;
  localparam cycle_t C_5 = 6'b100000;

  localparam seq_sel_t SEQ_NON = 2'd0;
  localparam seq_sel_t SEQ_RST = 2'd1;
  localparam seq_sel_t SEQ_NMI = 2'd2;
  localparam seq_sel_t SEQ_IRQ = 2'd3;

endpackage

// File: rtl/k6502_nmi_det.sv
// NMI falling-edge detector with a pending latch; runs regardless of rdy.
module k6502_nmi_det (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic clr,
  output logic pend
);

  logic nmi_q;
  logic pend_q;
  logic pend_d;

  // A new edge beats a same-cycle clear so back-to-back NMIs are not lost.
  always_comb begin
    pend_d = pend_q;
    if (nmi_q && !nmi_n) begin
      pend_d = 1'b1;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    nmi_q <= nmi_n;
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/k6502_seq.sv
// k6502 cycle sequencer: instruction register, one-hot cycle counter and
// reset/NMI/IRQ sequence select that together address the microcode decoder.
module k6502_seq
  import k6502_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] di,
  input  logic       sync_next,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       flag_i,
  output logic [7:0] ir,
  output logic [5:0] cycle,
  output logic       seq_rst,
  output logic       seq_nmi,
  output logic       seq_irq,
  output logic       sync,
  output logic       err
);

  logic [7:0] ir_q, ir_d;
  cycle_t     cycle_q, cycle_d;
  seq_sel_t   seq_q, seq_d;
  logic       err_q, err_d;
  logic       nmi_pend;
  logic       nmi_clr;

  // NMI is consumed only on a real fetch decision (rdy high, no sync_next).
  assign nmi_clr = rdy && !sync_next && (cycle_q == C_N) && nmi_pend;

  k6502_nmi_det u_nmi (
    .clk   (clk),
    .rst   (rst),
    .nmi_n (nmi_n),
    .clr   (nmi_clr),
    .pend  (nmi_pend)
  );

  always_comb begin
    ir_d    = ir_q;
    cycle_d = cycle_q;
    seq_d   = seq_q;
    err_d   = err_q;
    if (rdy) begin
      if (sync_next) begin
        cycle_d = C_N;
        seq_d   = SEQ_NON;
      end else if (cycle_q == C_N) begin
        cycle_d = C_0;
        if (nmi_pend) begin
          ir_d  = 8'h00;
          seq_d = SEQ_NMI;
        end else if (!irq_n && !flag_i) begin
          ir_d  = 8'h00;
          seq_d = SEQ_IRQ;
        end else begin
          ir_d  = di;
          seq_d = SEQ_NON;
        end
      end else if (cycle_q == C_5) begin
        cycle_d = C_N;
        seq_d   = SEQ_NON;
        err_d   = 1'b1;
      end else begin
        cycle_d = cycle_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q    <= 8'h00;
      cycle_q <= C_0;
      seq_q   <= SEQ_RST;
      err_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      cycle_q <= cycle_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign ir      = ir_q;
  assign cycle   = cycle_q;
  assign seq_rst = (seq_q == SEQ_RST);
  assign seq_nmi = (seq_q == SEQ_NMI);
  assign seq_irq = (seq_q == SEQ_IRQ);
  assign sync    = ~|cycle_q;
  assign err     = err_q;

endmodule

// File: tb/tb_k6502_seq.sv
// Directed bench for k6502_seq: vector table plus hand-written NMI, stall,
// overrun and reset sequences.
module tb_k6502_seq;

  logic       clk;
  logic       rst, rdy, sync_next, nmi_n, irq_n, flag_i;
  logic [7:0] di;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       seq_rst, seq_nmi, seq_irq, sync, err;

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];

  typedef struct {
    logic       r, rd, sn;
    logic [7:0] d;
    logic       nn, iq, fi;
    logic [7:0] e_ir;
    logic [5:0] e_cyc;
    logic [2:0] e_seq;
    logic       e_err;
  } vec_t;

  vec_t vecs[20];

  k6502_seq dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .di        (di),
    .sync_next (sync_next),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .flag_i    (flag_i),
    .ir        (ir),
    .cycle     (cycle),
    .seq_rst   (seq_rst),
    .seq_nmi   (seq_nmi),
    .seq_irq   (seq_irq),
    .sync      (sync),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs mid-cycle, clock once, then compare against expectations.
  task automatic step(input string name, input logic r, input logic rd, input logic sn,
                      input logic [7:0] d, input logic nn, input logic iq, input logic fi,
                      input logic [7:0] e_ir, input logic [5:0] e_cyc,
                      input logic [2:0] e_seq, input logic e_err);
    logic [18:0] exp_v;
    logic [18:0] act_v;
    @(negedge clk);
    rst = r; rdy = rd; sync_next = sn; di = d; nmi_n = nn; irq_n = iq; flag_i = fi;
    @(posedge clk);
    #1;
    exp_q.push_back({e_ir, e_cyc, e_seq, e_err, (e_cyc == 6'b0)});
    exp_v = exp_q.pop_front();
    act_v = {ir, cycle, seq_rst, seq_nmi, seq_irq, err, sync};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got ir=%h cycle=%b seq=%b err=%b sync=%b, want ir=%h cycle=%b seq=%b err=%b sync=%b",
               name, act_v[18:11], act_v[10:5], act_v[4:2], act_v[1], act_v[0],
               exp_v[18:11], exp_v[10:5], exp_v[4:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic chk_pend(input string name, input logic e);
    n_checks++;
    if (dut.nmi_pend !== e) begin
      n_errors++;
      $display("FAIL %s: nmi_pend got %b want %b", name, dut.nmi_pend, e);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; sync_next = 1'b0; di = 8'h00;
    nmi_n = 1'b1; irq_n = 1'b1; flag_i = 1'b1;

    //        r  rd sn di     nn iq fi  ir     cycle      seq     err
    vecs[0]  = '{1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000001, 3'b100, 0};
    vecs[1]  = '{1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000001, 3'b100, 0};
    vecs[2]  = '{0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000010, 3'b100, 0};
    vecs[3]  = '{0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000100, 3'b100, 0};
    vecs[4]  = '{0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b001000, 3'b100, 0};
    vecs[5]  = '{0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b010000, 3'b100, 0};
    vecs[6]  = '{0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 6'b000000, 3'b000, 0};
    vecs[7]  = '{0, 1, 0, 8'hEA, 1, 1, 1, 8'hEA, 6'b000001, 3'b000, 0};
    vecs[8]  = '{0, 1, 0, 8'h00, 1, 1, 1, 8'hEA, 6'b000010, 3'b000, 0};
    vecs[9]  = '{0, 1, 1, 8'h00, 1, 1, 1, 8'hEA, 6'b000000, 3'b000, 0};
    vecs[10] = '{0, 1, 0, 8'hAD, 1, 1, 1, 8'hAD, 6'b000001, 3'b000, 0};
    vecs[11] = '{0, 1, 0, 8'h00, 1, 1, 1, 8'hAD, 6'b000010, 3'b000, 0};
    vecs[12] = '{0, 1, 0, 8'h00, 1, 1, 1, 8'hAD, 6'b000100, 3'b000, 0};
    vecs[13] = '{0, 1, 0, 8'h00, 1, 1, 1, 8'hAD, 6'b001000, 3'b000, 0};
    vecs[14] = '{0, 1, 1, 8'h00, 1, 1, 1, 8'hAD, 6'b000000, 3'b000, 0};
    vecs[15] = '{0, 1, 0, 8'h58, 1, 0, 1, 8'h58, 6'b000001, 3'b000, 0};
    vecs[16] = '{0, 1, 1, 8'h00, 1, 1, 1, 8'h58, 6'b000000, 3'b000, 0};
    vecs[17] = '{0, 1, 0, 8'hFF, 1, 0, 0, 8'h00, 6'b000001, 3'b001, 0};
    vecs[18] = '{0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000010, 3'b001, 0};
    vecs[19] = '{0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 6'b000000, 3'b000, 0};

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].rd, vecs[i].sn, vecs[i].d,
           vecs[i].nn, vecs[i].iq, vecs[i].fi, vecs[i].e_ir, vecs[i].e_cyc,
           vecs[i].e_seq, vecs[i].e_err);
    end

    // NMI edge during C_1, then NMI beats a simultaneous IRQ; IRQ follows.
    step("nmi_fetch_op", 0, 1, 0, 8'hEA, 1, 1, 1, 8'hEA, 6'b000001, 3'b000, 0);
    step("nmi_c1",       0, 1, 0, 8'h00, 1, 1, 1, 8'hEA, 6'b000010, 3'b000, 0);
    step("nmi_edge",     0, 1, 0, 8'h00, 0, 1, 1, 8'hEA, 6'b000100, 3'b000, 0);
    chk_pend("nmi_pend_set", 1'b1);
    step("nmi_end",      0, 1, 1, 8'h00, 0, 1, 1, 8'hEA, 6'b000000, 3'b000, 0);
    step("nmi_take",     0, 1, 0, 8'h4C, 0, 0, 0, 8'h00, 6'b000001, 3'b010, 0);
    chk_pend("nmi_pend_clr", 1'b0);
    step("nmi_seq_end",  0, 1, 1, 8'h00, 1, 0, 0, 8'h00, 6'b000000, 3'b000, 0);
    step("irq_after",    0, 1, 0, 8'h4C, 1, 0, 0, 8'h00, 6'b000001, 3'b001, 0);

    // Second falling edge on the very clock that consumes the first.
    step("nmi2_edge",    0, 1, 0, 8'h00, 0, 1, 1, 8'h00, 6'b000010, 3'b001, 0);
    step("nmi2_rise",    0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 6'b000000, 3'b000, 0);
    step("nmi2_take",    0, 1, 0, 8'hEA, 0, 1, 1, 8'h00, 6'b000001, 3'b010, 0);
    chk_pend("nmi_pend_set_wins", 1'b1);
    step("nmi2_end",     0, 1, 1, 8'h00, 0, 1, 1, 8'h00, 6'b000000, 3'b000, 0);
    step("nmi3_take",    0, 1, 0, 8'hEA, 1, 1, 1, 8'h00, 6'b000001, 3'b010, 0);
    chk_pend("nmi_pend_clr2", 1'b0);

    // Stall at C_2 for three clocks with an NMI edge in the middle.
    step("stall_c1",     0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000010, 3'b010, 0);
    step("stall_c2",     0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000100, 3'b010, 0);
    step("stall_0",      0, 0, 1, 8'h11, 1, 0, 0, 8'h00, 6'b000100, 3'b010, 0);
    step("stall_1",      0, 0, 0, 8'h22, 0, 1, 1, 8'h00, 6'b000100, 3'b010, 0);
    step("stall_2",      0, 0, 0, 8'h33, 0, 1, 1, 8'h00, 6'b000100, 3'b010, 0);
    chk_pend("stall_nmi_latched", 1'b1);
    step("stall_go",     0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b001000, 3'b010, 0);
    step("stall_end",    0, 1, 1, 8'h00, 1, 1, 1, 8'h00, 6'b000000, 3'b000, 0);
    step("stall_nmi",    0, 1, 0, 8'hEA, 1, 1, 1, 8'h00, 6'b000001, 3'b010, 0);

    // Overrun: no sync_next, C_5 falls into C_N with err set and sticky.
    step("ovr_c1",       0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000010, 3'b010, 0);
    step("ovr_c2",       0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000100, 3'b010, 0);
    step("ovr_c3",       0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b001000, 3'b010, 0);
    step("ovr_c4",       0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b010000, 3'b010, 0);
    step("ovr_c5",       0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b100000, 3'b010, 0);
    step("ovr_cn",       0, 1, 0, 8'h00, 1, 1, 1, 8'h00, 6'b000000, 3'b000, 1);
    step("ovr_fetch",    0, 1, 0, 8'hA9, 1, 1, 1, 8'hA9, 6'b000001, 3'b000, 1);
    step("ovr_end",      0, 1, 1, 8'h00, 1, 1, 1, 8'hA9, 6'b000000, 3'b000, 1);
    step("ovr_fetch2",   0, 1, 0, 8'hEA, 1, 1, 1, 8'hEA, 6'b000001, 3'b000, 1);
    step("ovr_c1b",      0, 1, 0, 8'h00, 1, 1, 1, 8'hEA, 6'b000010, 3'b000, 1);
    step("ovr_c2b",      0, 1, 0, 8'h00, 1, 1, 1, 8'hEA, 6'b000100, 3'b000, 1);
    step("ovr_c3b",      0, 1, 0, 8'h00, 1, 1, 1, 8'hEA, 6'b001000, 3'b000, 1);

    // Reset mid-instruction with rdy low and NMI held low through reset.
    step("rst_mid",      1, 0, 0, 8'h00, 0, 1, 1, 8'h00, 6'b000001, 3'b100, 0);
    step("rst_rel",      0, 1, 0, 8'h00, 0, 1, 1, 8'h00, 6'b000010, 3'b100, 0);
    chk_pend("rst_no_nmi_edge", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
